// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the keyboard clock, frames 11-bit
// packets, and reports make codes (with E0 prefix) to the MCU via SCANCODE/INTRPT.
module ps2_keyboard_rx #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned INTR_CYCLES    = 4
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       PS2CLK,
   input  logic       PS2DATA,
   output logic [7:0] SCANCODE,
   output logic       INTRPT,
   output logic       EXTENDED,
   output logic       ERROR
);

   localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
   localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned IntrW = $clog2(INTR_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

   state_e           state_q, state_d;
   logic [1:0]       clk_sync_q, data_sync_q;
   logic             filt_q, filt_d;
   logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [9:0]       shift_q, shift_d;
   logic [ToW-1:0]   to_cnt_q, to_cnt_d;
   logic             ext_flag_q, ext_flag_d;
   logic             brk_flag_q, brk_flag_d;
   logic [7:0]       scancode_q, scancode_d;
   logic             extended_q, extended_d;
   logic [IntrW-1:0] intr_cnt_q, intr_cnt_d;
   logic             error_q, error_d;

   logic       clk_s, data_s;
   logic       fall;
   logic       timeout;
   logic [7:0] frame_byte;
   logic       frame_ok;

   // Synchronisers reset to 1 so an idle bus looks idle straight out of reset.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], PS2CLK};
         data_sync_q <= {data_sync_q[0], PS2DATA};
      end
   end

   assign clk_s  = clk_sync_q[1];
   assign data_s = data_sync_q[1];

   // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_s != filt_q) begin
         if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
            filt_d = clk_s;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   assign fall       = filt_q & ~filt_d;
   assign timeout    = (state_q == StRecv) && !fall && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
   assign frame_byte = shift_q[7:0];
   assign frame_ok   = (^shift_q[8:0]) & shift_q[9];

   // FSM state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (fall && !data_s) begin
               state_d = StRecv;
            end
         end
         StRecv: begin
            if (timeout) begin
               state_d = StIdle;
            end else if (fall && (bit_cnt_q == 4'd10)) begin
               state_d = StCheck;
            end
         end
         StCheck: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs and datapath next state
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      to_cnt_d   = to_cnt_q;
      ext_flag_d = ext_flag_q;
      brk_flag_d = brk_flag_q;
      scancode_d = scancode_q;
      extended_d = extended_q;
      error_d    = 1'b0;
      intr_cnt_d = (intr_cnt_q != '0) ? intr_cnt_q - 1'b1 : intr_cnt_q;

      unique case (state_q)
         StIdle: begin
            to_cnt_d  = '0;
            bit_cnt_d = (fall && !data_s) ? 4'd1 : 4'd0;
         end
         StRecv: begin
            if (timeout) begin
               error_d    = 1'b1;
               ext_flag_d = 1'b0;
               brk_flag_d = 1'b0;
               bit_cnt_d  = '0;
               to_cnt_d   = '0;
            end else if (fall) begin
               // LSB-first: after ten shifts bit 0 holds D0 and bit 9 holds the stop bit.
               shift_d   = {data_s, shift_q[9:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               to_cnt_d  = '0;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StCheck: begin
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            if (!frame_ok) begin
               error_d    = 1'b1;
               ext_flag_d = 1'b0;
               brk_flag_d = 1'b0;
            end else if (frame_byte == 8'hE0) begin
               ext_flag_d = 1'b1;
            end else if (frame_byte == 8'hF0) begin
               brk_flag_d = 1'b1;
            end else if (brk_flag_q) begin
               ext_flag_d = 1'b0;
               brk_flag_d = 1'b0;
            end else begin
               scancode_d = frame_byte;
               extended_d = ext_flag_q;
               ext_flag_d = 1'b0;
               intr_cnt_d = IntrW'(INTR_CYCLES);
            end
         end
         default: begin
            bit_cnt_d = '0;
            to_cnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         to_cnt_q   <= '0;
         ext_flag_q <= 1'b0;
         brk_flag_q <= 1'b0;
         scancode_q <= '0;
         extended_q <= 1'b0;
         intr_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         to_cnt_q   <= to_cnt_d;
         ext_flag_q <= ext_flag_d;
         brk_flag_q <= brk_flag_d;
         scancode_q <= scancode_d;
         extended_q <= extended_d;
         intr_cnt_q <= intr_cnt_d;
         error_q    <= error_d;
      end
   end

   assign SCANCODE = scancode_q;
   assign EXTENDED = extended_q;
   assign INTRPT   = (intr_cnt_q != '0);
   assign ERROR    = error_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: scripted frame table, random frames against a byte-level
// model of the make/break/extended rules, and hand sequences for timeout, glitch and reset.
module tb_ps2_keyboard_rx;

   localparam int unsigned TimeoutCycles = 2000;
   localparam int unsigned IntrCycles    = 4;

   logic       clk;
   logic       rst_n;
   logic       ps2clk;
   logic       ps2data;
   logic [7:0] scancode;
   logic       intrpt;
   logic       extended;
   logic       error;

   int n_checks = 0;
   int n_fail   = 0;

   int   intr_pulses = 0;
   int   intr_hi     = 0;
   int   err_hi      = 0;
   logic intr_prev   = 1'b0;

   // Byte-level reference state
   logic [7:0] m_sc;
   logic       m_ext;
   logic       m_ef;
   logic       m_bf;

   typedef struct {
      logic [7:0] data;
      logic       bad_par;
      logic [7:0] exp_sc;
      logic       exp_ext;
      int         exp_pulses;
      int         exp_err;
   } vec_t;

   vec_t vecs[9];

   ps2_keyboard_rx #(
      .FILTER_LEN    (8),
      .TIMEOUT_CYCLES(TimeoutCycles),
      .INTR_CYCLES   (IntrCycles)
   ) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .PS2CLK  (ps2clk),
      .PS2DATA (ps2data),
      .SCANCODE(scancode),
      .INTRPT  (intrpt),
      .EXTENDED(extended),
      .ERROR   (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (intrpt && !intr_prev) intr_pulses++;
      if (intrpt) intr_hi++;
      if (error) err_hi++;
      intr_prev = intrpt;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ps2data = b;
      wait_clk(15);
      ps2clk = 1'b0;
      wait_clk(25);
      ps2clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      send_bit(stop);
      ps2data = 1'b1;
      wait_clk(15);
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   task automatic model_reset();
      m_sc  = 8'h00;
      m_ext = 1'b0;
      m_ef  = 1'b0;
      m_bf  = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b, input logic par, input logic stop,
                              output int pulses, output int errs);
      pulses = 0;
      errs   = 0;
      if (($countones({b, par}) % 2 != 1) || !stop) begin
         errs = 1;
         m_ef = 1'b0;
         m_bf = 1'b0;
      end else if (b == 8'hE0) begin
         m_ef = 1'b1;
      end else if (b == 8'hF0) begin
         m_bf = 1'b1;
      end else if (m_bf) begin
         m_bf = 1'b0;
         m_ef = 1'b0;
      end else begin
         m_sc   = b;
         m_ext  = m_ef;
         m_ef   = 1'b0;
         pulses = 1;
      end
   endtask

   task automatic frame_check(input string tag, input logic [7:0] b, input logic par,
                              input logic stop, input logic [7:0] exp_sc, input logic exp_ext,
                              input int exp_pulses, input int exp_err);
      int p0, h0, e0;
      p0 = intr_pulses;
      h0 = intr_hi;
      e0 = err_hi;
      send_frame(b, par, stop);
      check({tag, " scancode"}, 32'(scancode), 32'(exp_sc));
      check({tag, " extended"}, 32'(extended), 32'(exp_ext));
      check({tag, " intr pulses"}, 32'(intr_pulses - p0), 32'(exp_pulses));
      check({tag, " intr cycles"}, 32'(intr_hi - h0), 32'(exp_pulses * IntrCycles));
      check({tag, " error cycles"}, 32'(err_hi - e0), 32'(exp_err));
   endtask

   // Runs one frame through the model, then checks the DUT against it.
   task automatic model_check(input string tag, input logic [7:0] b, input logic par,
                              input logic stop);
      int pulses, errs;
      model_frame(b, par, stop, pulses, errs);
      frame_check(tag, b, par, stop, m_sc, m_ext, pulses, errs);
   endtask

   initial begin
      int         p0, e0, pulses, errs;
      logic [7:0] rb;
      logic       bad_par, bad_stop;
      logic [7:0] bits5a;

      vecs[0] = '{8'h1C, 1'b0, 8'h1C, 1'b0, 1, 0};
      vecs[1] = '{8'hF0, 1'b0, 8'h1C, 1'b0, 0, 0};
      vecs[2] = '{8'h1C, 1'b0, 8'h1C, 1'b0, 0, 0};
      vecs[3] = '{8'hE0, 1'b0, 8'h1C, 1'b0, 0, 0};
      vecs[4] = '{8'h75, 1'b0, 8'h75, 1'b1, 1, 0};
      vecs[5] = '{8'h1C, 1'b1, 8'h75, 1'b1, 0, 1};
      vecs[6] = '{8'hF0, 1'b0, 8'h75, 1'b1, 0, 0};
      vecs[7] = '{8'h55, 1'b1, 8'h75, 1'b1, 0, 1};
      vecs[8] = '{8'h29, 1'b0, 8'h29, 1'b0, 1, 0};

      rst_n   = 1'b0;
      ps2clk  = 1'b1;
      ps2data = 1'b1;
      model_reset();
      #12;
      check("reset scancode", 32'(scancode), 32'h0);
      check("reset intrpt", 32'(intrpt), 32'h0);
      check("reset extended", 32'(extended), 32'h0);
      check("reset error", 32'(error), 32'h0);
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(5);

      for (int i = 0; i < 9; i++) begin
         logic par;
         par = odd_par(vecs[i].data) ^ vecs[i].bad_par;
         model_frame(vecs[i].data, par, 1'b1, pulses, errs);
         frame_check($sformatf("vec%0d", i), vecs[i].data, par, 1'b1, vecs[i].exp_sc,
                     vecs[i].exp_ext, vecs[i].exp_pulses, vecs[i].exp_err);
      end

      for (int i = 0; i < 40; i++) begin
         int sel;
         sel = int'($urandom_range(0, 9));
         rb  = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
         bad_par  = ($urandom_range(0, 4) == 0);
         bad_stop = ($urandom_range(0, 9) == 0);
         model_check($sformatf("rand%0d", i), rb, odd_par(rb) ^ bad_par, !bad_stop);
      end

      // Timeout: a pending break prefix must be dropped by the abort.
      model_check("pre-timeout F0", 8'hF0, odd_par(8'hF0), 1'b1);
      p0 = intr_pulses;
      e0 = err_hi;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      ps2data = 1'b1;
      wait_clk(1900);
      check("timeout early error", 32'(err_hi - e0), 32'h0);
      wait_clk(200);
      check("timeout error", 32'(err_hi - e0), 32'h1);
      check("timeout intr", 32'(intr_pulses - p0), 32'h0);
      m_ef = 1'b0;
      m_bf = 1'b0;
      model_check("post-timeout 29", 8'h29, odd_par(8'h29), 1'b1);

      // 3-cycle clock glitch with data low would look like a start bit if not filtered.
      e0 = err_hi;
      wait_clk(5);
      ps2data = 1'b0;
      ps2clk  = 1'b0;
      wait_clk(3);
      ps2clk = 1'b1;
      wait_clk(3);
      ps2data = 1'b1;
      wait_clk(30);
      check("glitch error", 32'(err_hi - e0), 32'h0);
      check("glitch scancode", 32'(scancode), 32'(m_sc));
      model_check("post-glitch 1C", 8'h1C, odd_par(8'h1C), 1'b1);

      // Reset mid-frame, with EXTENDED and SCANCODE non-zero beforehand.
      model_check("pre-reset E0", 8'hE0, odd_par(8'hE0), 1'b1);
      model_check("pre-reset 75", 8'h75, odd_par(8'h75), 1'b1);
      bits5a = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(bits5a[i]);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset scancode", 32'(scancode), 32'h0);
      check("async reset extended", 32'(extended), 32'h0);
      check("async reset intrpt", 32'(intrpt), 32'h0);
      check("async reset error", 32'(error), 32'h0);
      model_reset();
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(3);
      p0 = intr_pulses;
      for (int i = 5; i < 8; i++) send_bit(bits5a[i]);
      send_bit(odd_par(8'h5A));
      send_bit(1'b1);
      ps2data = 1'b1;
      wait_clk(2100);
      check("tail intr", 32'(intr_pulses - p0), 32'h0);
      check("tail scancode", 32'(scancode), 32'h0);
      model_check("post-reset 5A", 8'h5A, odd_par(8'h5A), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
